pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits.
REQ-002 Parameter STALL_W, 10, width of the global stall vector.
REQ-003 Parameter STAGE_IDX, 8, stall bit owned by this stage; STAGE_IDX+1 < STALL_W SHALL hold (elaboration error otherwise).
REQ-004 Parameter CNT_W, 16, bubble counter width.
REQ-005 Reset rst, synchronous, active-high; clock clk.
REQ-006 Ports SHALL be exactly:
  clk  in  1  clock
  rst  in  1  sync active-high reset
  flush  in  1  discard all held entries
  stall  in  STALL_W  global stall vector, 1 = Stop
  in_valid  in  1  upstream payload valid
  in_ready  out  1  stage accepts payload this cycle
  in_data  in  WIDTH  upstream payload
  out_valid  out  1  downstream payload valid
  out_ready  in  1  downstream accepts payload
  out_data  out  WIDTH  downstream payload
  bubble_cnt  out  CNT_W  count of inserted bubbles

Function
REQ-007 Accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated on the same edge.
REQ-008 Per-edge priority SHALL be: rst > flush > bubble > hold > handshake.
REQ-009 Bubble condition: stall[STAGE_IDX]=1 & stall[STAGE_IDX+1]=0; the output slot is released (TWO->ONE with skid promoted to main, ONE->EMPTY, EMPTY stays EMPTY), no accept, regardless of out_ready.
REQ-010 Hold condition: stall[STAGE_IDX]=1 & stall[STAGE_IDX+1]=1; state and data SHALL not change.
REQ-011 in_ready SHALL be 0 whenever stall[STAGE_IDX]=1 or flush=1.
REQ-012 out_valid SHALL equal main-slot occupancy; out_data SHALL be all-zero when out_valid=0.
REQ-013 Accept-to-out_valid latency SHALL be 1 cycle when the stage is EMPTY.
REQ-014 Payload order SHALL be preserved; no payload duplicated or dropped except by flush/rst.
REQ-015 flush SHALL empty all slots and zero data on the next edge; a simultaneous accept is discarded.
REQ-016 bubble_cnt SHALL increment by 1 on each bubble-condition edge and saturate at all-ones.
REQ-017 flush SHALL NOT clear bubble_cnt.

Reset
REQ-018 On rst: state EMPTY, all data registers zero, out_valid=0, out_data=0, bubble_cnt=0; in_ready=1 on the first post-reset cycle unless stalled.
REQ-019 rst asserted mid-transfer SHALL discard all held payloads without emitting them.

Configuration
REQ-020 Macro PIPE_STAGE_SKID_EN defined: main+skid slots, states EMPTY/ONE/TWO; in_ready = (state!=TWO) & ~stall[STAGE_IDX] & ~flush (no out_ready dependence).
REQ-021 Transitions with skid: EMPTY+accept->ONE; ONE+accept&~drain->TWO; ONE+~accept&drain->EMPTY; ONE+accept&drain->ONE (main<=in_data); TWO+drain->ONE (main<=skid).
REQ-022 Macro undefined: single slot, states EMPTY/FULL; in_ready = (EMPTY | out_ready) & ~stall[STAGE_IDX] & ~flush; accept&drain in FULL stays FULL with new data.

Structure
REQ-023 State encodings, Stop/NoStop polarity and default WIDTH/STALL_W SHALL reside in the shared defines/package.
REQ-024 The saturating counter SHALL be a separate sub-module, sat_counter (parameter CNT_W, ports clk, rst, inc, cnt).

Verification
REQ-025 WIDTH=8, SKID on: accept 0x11, 0x22 with out_ready=0 -> state TWO, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 on successive cycles.
REQ-026 Stage FULL with 0x5A, stall[8]=1, stall[9]=0 for 3 cycles -> out_valid=0, out_data=0x00 after first edge, bubble_cnt=3.
REQ-027 stall[8]=1, stall[9]=1 with 0xA5 held -> out_data stays 0xA5, out_valid=1, in_ready=0, bubble_cnt unchanged.
REQ-028 State TWO, flush=1 with in_valid=1, in_data=0x77 -> next cycle EMPTY, out_valid=0, 0x77 never emitted.
REQ-029 CNT_W=2: 5 bubble cycles -> bubble_cnt=3; then rst -> 0.
REQ-030 SKID off: continuous in_valid=1, out_ready=1, data 0..9 -> out_data 0..9 back-to-back, in_ready constantly 1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: slot-state encodings, stall polarity
// and default payload/stall-vector widths.
package pipe_stage_reg_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_STALL_W = 10;

    // Stall vector polarity: a set bit stops the owning stage.
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // ST_ONE doubles as FULL in the single-slot build.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam stage_state_t ST_FULL = ST_ONE;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, sync
// active-high reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_ONE;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Stallable pipeline stage register with bubble insertion and bubble counter.
// Define PIPE_STAGE_SKID_EN for a main+skid two-entry stage; default is one slot.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STALL_W   = DEF_STALL_W,
    parameter int STAGE_IDX = 8,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]   bubble_cnt
);

    if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
    end

    logic w_stop, w_stop_next, w_bubble, w_hold;
    logic w_in_ready, w_accept, w_drain;
    logic w_unused_stall;

    stage_state_t     r_state, w_state_nxt;
    logic [WIDTH-1:0] r_main, w_main_nxt;

    assign w_stop      = (stall[STAGE_IDX]   == STOP);
    assign w_stop_next = (stall[STAGE_IDX+1] == STOP);
    // Downstream moving while we are stopped: release our slot as a bubble.
    assign w_bubble    = w_stop & ~w_stop_next;
    assign w_hold      = w_stop & w_stop_next;
    assign w_unused_stall = ^stall;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] r_skid, w_skid_nxt;

    assign w_in_ready = (r_state != ST_TWO) & ~w_stop & ~flush;
`else
    assign w_in_ready = ((r_state == ST_EMPTY) | out_ready) & ~w_stop & ~flush;
`endif

    assign w_accept = in_valid & w_in_ready;
    assign w_drain  = out_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    // Empty slots are held at zero, so the main register is already gated.
    assign out_data  = r_main;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
`ifdef PIPE_STAGE_SKID_EN
            r_skid  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
`ifdef PIPE_STAGE_SKID_EN
            r_skid  <= w_skid_nxt;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else if (w_bubble) begin
            case (r_state)
                ST_TWO: begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = '0;
                end
                ST_ONE: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = '0;
                end
                default: ;
            endcase
        end else if (!w_hold) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt  = in_data;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
        end else if (w_bubble) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
        end else if (!w_hold) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    // In FULL an accept implies a drain (in_ready needs out_ready).
                    if (w_accept) begin
                        w_main_nxt  = in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = '0;
                end
            endcase
        end
    end
`endif

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_bubble),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// phase, all checked against a payload scoreboard queue.
module tb_pipe_stage_reg;

    localparam int W   = 8;
    localparam int SW  = 10;
    localparam int IDX = 8;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [SW-1:0] stall;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, in_ready2, out_valid2;
    logic [W-1:0]  out_data, out_data2;
    logic [15:0]   bubble_cnt;
    logic [1:0]    bubble_cnt2;

    int            n_chk = 0;
    int            n_pass = 0;
    int            exp_bub = 0;
    logic [W-1:0]  q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .STALL_W(SW), .STAGE_IDX(IDX), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.WIDTH(W), .STALL_W(SW), .STAGE_IDX(IDX), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .bubble_cnt(bubble_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: compare both DUTs against the scoreboard mid-cycle, then
    // advance the scoreboard by the same edge rules the stage follows.
    task automatic cyc();
        logic         exp_ov, exp_rdy, acc, drn, bub, hld;
        logic [W-1:0] exp_od;
        #4;
        bub     = stall[IDX] & ~stall[IDX+1];
        hld     = stall[IDX] & stall[IDX+1];
        exp_ov  = (q.size() != 0);
        exp_od  = exp_ov ? q[0] : '0;
        exp_rdy = (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready)) && !stall[IDX] && !flush;
        n_chk++;
        if (out_valid !== exp_ov || out_data !== exp_od || in_ready !== exp_rdy)
            $display("FAIL outputs t=%0t: valid/data/ready=%b/%h/%b expected %b/%h/%b",
                     $time, out_valid, out_data, in_ready, exp_ov, exp_od, exp_rdy);
        else n_pass++;
        n_chk++;
        if (out_valid2 !== exp_ov || out_data2 !== exp_od || in_ready2 !== exp_rdy)
            $display("FAIL outputs2 t=%0t: valid/data/ready=%b/%h/%b expected %b/%h/%b",
                     $time, out_valid2, out_data2, in_ready2, exp_ov, exp_od, exp_rdy);
        else n_pass++;
        n_chk++;
        if (bubble_cnt !== 16'(exp_bub) || bubble_cnt2 !== 2'(exp_bub > 3 ? 3 : exp_bub))
            $display("FAIL bubble_cnt t=%0t: got %0d/%0d expected %0d/%0d",
                     $time, bubble_cnt, bubble_cnt2, exp_bub, (exp_bub > 3 ? 3 : exp_bub));
        else n_pass++;
        acc = in_valid & exp_rdy;
        drn = exp_ov & out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_bub = 0;
        end else begin
            if (bub && exp_bub < 65535) exp_bub++;
            if (flush) q.delete();
            else if (bub) begin
                if (q.size() != 0) void'(q.pop_front());
            end else if (!hld) begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
        end
    endtask

    task automatic idle();
        flush = 1'b0; stall = '0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        exp_bub = 0;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || bubble_cnt !== 16'd0 || in_ready !== 1'b1)
            $display("FAIL reset: valid/data/cnt/ready=%b/%h/%0d/%b expected 0/00/0/1",
                     out_valid, out_data, bubble_cnt, in_ready);
        else n_pass++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            cyc();
            if (i == 0) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== 8'h00)
                    $display("FAIL stream_latency: valid/data=%b/%h expected 1/00", out_valid, out_data);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        n_chk++;
        if (out_valid !== 1'b0 || q.size() != 0)
            $display("FAIL stream_drain: valid=%b left=%0d expected 0/0", out_valid, q.size());
        else n_pass++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        cyc();
        in_valid  = 1'b0;
        stall[IDX] = 1'b1;
        stall[IDX+1] = 1'b0;
        cyc();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL bubble_release: valid/data=%b/%h expected 0/00", out_valid, out_data);
        else n_pass++;
        cyc();
        cyc();
        stall = '0;
        n_chk++;
        if (bubble_cnt !== 16'd3)
            $display("FAIL bubble_count: got %0d expected 3", bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        cyc();
        stall[IDX]   = 1'b1;
        stall[IDX+1] = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b1;
        repeat (3) cyc();
        #4;
        n_chk++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1 || in_ready !== 1'b0 || bubble_cnt !== 16'd3)
            $display("FAIL hold: data/valid/ready/cnt=%h/%b/%b/%0d expected a5/1/0/3",
                     out_data, out_valid, in_ready, bubble_cnt);
        else n_pass++;
        stall    = '0;
        in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cyc();
        in_data   = 8'h22;
        cyc();
        in_valid  = 1'b0;
        n_chk++;
        if (in_ready !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1)
            $display("FAIL backpressure: ready/data/valid=%b/%h/%b expected 0/11/1",
                     in_ready, out_data, out_valid);
        else n_pass++;
        out_ready = 1'b1;
        cyc();
`ifdef PIPE_STAGE_SKID_EN
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 8'h22)
            $display("FAIL skid_second: valid/data=%b/%h expected 1/22", out_valid, out_data);
        else n_pass++;
`endif
        cyc();
        cyc();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        cyc();
        in_data   = 8'h22;
        cyc();
        flush   = 1'b1;
        in_data = 8'h77;
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL flush: valid/data=%b/%h expected 0/00", out_valid, out_data);
        else n_pass++;
        repeat (3) cyc();
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        cyc();
        in_data   = 8'h55;
        cyc();
        rst     = 1'b1;
        in_data = 8'h99;
        cyc();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || bubble_cnt !== 16'd0)
            $display("FAIL rst_mid: valid/data/cnt=%b/%h/%0d expected 0/00/0", out_valid, out_data, bubble_cnt);
        else n_pass++;
        repeat (2) cyc();
    endtask

    task automatic test_saturate();
        in_valid     = 1'b1;
        in_data      = 8'h66;
        stall[IDX]   = 1'b1;
        stall[IDX+1] = 1'b0;
        repeat (5) cyc();
        n_chk++;
        if (bubble_cnt2 !== 2'd3 || bubble_cnt !== 16'd5)
            $display("FAIL saturate: cnt2/cnt=%0d/%0d expected 3/5", bubble_cnt2, bubble_cnt);
        else n_pass++;
        stall    = '0;
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        rst = 1'b0;
        n_chk++;
        if (bubble_cnt2 !== 2'd0 || bubble_cnt !== 16'd0)
            $display("FAIL saturate_rst: cnt2/cnt=%0d/%0d expected 0/0", bubble_cnt2, bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            stall     = SW'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            if (flush || $urandom_range(0, 3) != 0) stall[IDX+1 -: 2] = 2'b00;
            cyc();
        end
        idle();
        out_ready = 1'b1;
        repeat (4) cyc();
        n_chk++;
        if (q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL random_drain: left=%0d valid=%b expected 0/0", q.size(), out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubble();
        test_hold();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
